// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI master.
// The master and its clock divider both import this package.
package sd_spi_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        INIT = 2'd2
    } state_t;

    localparam int INIT_CLOCKS = 80;
    localparam int XFER_BITS   = 8;
    localparam int PHASE_W     = 8;
    localparam int BIT_W       = 7;
endpackage

// File: rtl/sd_spi_clkgen.sv
// Half-period divider: one-cycle tick every div cycles while enabled.
// A restart zeroes the phase so the first tick lands exactly div cycles later.
module sd_spi_clkgen
    import sd_spi_pkg::*;
(
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               restart,
    input  logic [PHASE_W-1:0] div,
    output logic               tick
);
    localparam logic [PHASE_W-1:0] ONE = 1;

    logic [PHASE_W-1:0] cnt;

    assign tick = enable && !restart && (cnt == div - ONE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end
endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for SD cards, with slow mode and an 80-clock wakeup burst.
// A byte transfer finishes 16*D+1 cycles after start; requests while busy are dropped.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int DIV_FAST = 2,
    parameter int DIV_SLOW = 80
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       init_req,
    input  logic       slow,
    input  logic       cs_assert,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sdclk,
    output logic       sdss,
    output logic       sdmosi,
    input  logic       sdmiso
);
    state_t             state, state_nxt;
    logic [PHASE_W-1:0] div_q;
    logic [6:0]         tx_shift;
    logic [7:0]         rx_shift;
    logic [BIT_W-1:0]   bit_cnt;
    logic               tick, rise, fall;
    logic               accept_start, accept_init, last_period;

    sd_spi_clkgen u_clkgen (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .enable  (state != IDLE),
        .restart (accept_start | accept_init),
        .div     (div_q),
        .tick    (tick)
    );

    assign busy = (state != IDLE);
    assign rise = tick && !sdclk;
    assign fall = tick && sdclk;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        accept_init  = 1'b0;
        last_period  = 1'b0;
        case (state)
            IDLE: begin
                if (init_req) begin
                    accept_init = 1'b1;
                    state_nxt   = INIT;
                end else if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = XFER;
                end
            end
            XFER: begin
                if (fall && bit_cnt == BIT_W'(XFER_BITS - 1)) begin
                    last_period = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            INIT: begin
                if (fall && bit_cnt == BIT_W'(INIT_CLOCKS - 1)) begin
                    last_period = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sdclk    <= 1'b0;
            sdss     <= 1'b1;
            sdmosi   <= 1'b1;
            done     <= 1'b0;
            rx_byte  <= 8'h00;
            div_q    <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= last_period;
            case (state)
                IDLE: begin
                    sdclk   <= 1'b0;
                    sdmosi  <= 1'b1;
                    sdss    <= ~cs_assert;
                    bit_cnt <= '0;
                    if (accept_init) begin
                        div_q <= slow ? PHASE_W'(DIV_SLOW) : PHASE_W'(DIV_FAST);
                        sdss  <= 1'b1;
                    end else if (accept_start) begin
                        div_q    <= slow ? PHASE_W'(DIV_SLOW) : PHASE_W'(DIV_FAST);
                        tx_shift <= tx_byte[6:0];
                        sdmosi   <= tx_byte[7];
                        rx_shift <= '0;
                    end
                end
                XFER: begin
                    if (tick) sdclk <= ~sdclk;
                    if (rise) rx_shift <= {rx_shift[6:0], sdmiso};
                    if (fall) begin
                        if (last_period) begin
                            rx_byte <= rx_shift;
                            sdmosi  <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            sdmosi   <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                INIT: begin
                    sdss   <= 1'b1;
                    sdmosi <= 1'b1;
                    if (tick) sdclk <= ~sdclk;
                    if (fall) bit_cnt <= last_period ? '0 : bit_cnt + 1'b1;
                end
                default: begin
                    sdclk  <= 1'b0;
                    sdmosi <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_master.sv
// Randomised scoreboard bench: driver queues expected results, monitor checks each done.
// Card model answers a byte on sdmiso; loopback mode ties sdmiso to sdmosi.
module tb_sd_spi_master;
    localparam int DF = 2;
    localparam int DS = 80;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         done_cyc;
        int         rises;
        bit         is_init;
        logic       ss;
    } exp_t;

    logic       clk_sys = 1'b0;
    logic       reset_n, start, init_req, slow, cs_assert, sdmiso;
    logic [7:0] tx_byte;
    logic       busy, done, sdclk, sdss, sdmosi;
    logic [7:0] rx_byte;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0, errors = 0;
    int         drv_timeouts = 0, n_expect = 0, n_done = 0;
    int         mon_rise = 0, zeros = 0, sdss_bad = 0, idle_bad = 0;
    logic [7:0] cap = 8'h00, model_rx = 8'h00, card_byte = 8'h00;
    bit         card_mode = 0, finish_req = 0, in_rst = 0, prev_sdclk = 0;

    sd_spi_master #(.DIV_FAST(DF), .DIV_SLOW(DS)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .start    (start),
        .tx_byte  (tx_byte),
        .init_req (init_req),
        .slow     (slow),
        .cs_assert(cs_assert),
        .busy     (busy),
        .done     (done),
        .rx_byte  (rx_byte),
        .sdclk    (sdclk),
        .sdss     (sdss),
        .sdmosi   (sdmosi),
        .sdmiso   (sdmiso)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Card shifts its reply MSB first, advancing after every rising SCK edge.
    assign sdmiso = card_mode ? card_byte[~mon_rise[2:0]] : sdmosi;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        if (!reset_n) begin
            if (!in_rst) begin
                chk("rst_sdclk", int'(sdclk), 0);
                chk("rst_sdss", int'(sdss), 1);
                chk("rst_sdmosi", int'(sdmosi), 1);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_rx_byte", int'(rx_byte), 0);
            end
            in_rst = 1;
            exp_q.delete();
            mon_rise = 0; cap = 8'h00; zeros = 0; sdss_bad = 0; prev_sdclk = 0;
        end else begin
            in_rst = 0;
            if (sdclk && !prev_sdclk) begin
                mon_rise++;
                cap = {cap[6:0], sdmosi};
                if (!sdmosi) zeros++;
            end
            prev_sdclk = sdclk;
            if (busy && exp_q.size() > 0 && sdss !== exp_q[0].ss) sdss_bad++;
            if (!busy && !done && sdmosi !== 1'b1) idle_bad++;
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_byte", int'(rx_byte), int'(e.rx));
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("sck_rises", mon_rise, e.rises);
                    chk("sdss_hold", sdss_bad, 0);
                    if (e.is_init) chk("init_mosi_zeros", zeros, 0);
                    else           chk("mosi_bits", int'(cap), int'(e.tx));
                end
                mon_rise = 0; cap = 8'h00; zeros = 0; sdss_bad = 0;
            end
        end
        if (finish_req || cyc > 95000) begin
            if (!finish_req) chk("global_timeout", cyc, 0);
            chk("drv_timeouts", drv_timeouts, 0);
            chk("done_count", n_done, n_expect);
            chk("pending_ops", exp_q.size(), 0);
            chk("idle_mosi_low", idle_bad, 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic issue(input bit init, input bit slw, input bit cs, input logic [7:0] tx,
                         input bit card, input logic [7:0] cb, input bit collide);
        exp_t e;
        int   d;
        cs_assert = cs;
        card_mode = card;
        card_byte = cb;
        repeat (2) @(posedge clk_sys);
        #1;
        d          = slw ? DS : DF;
        e.is_init  = init;
        e.rises    = init ? 80 : 8;
        e.done_cyc = cyc + 1 + (init ? 160 : 16) * d;
        e.ss       = init ? 1'b1 : ~cs;
        e.tx       = tx;
        e.rx       = init ? model_rx : (card ? cb : tx);
        model_rx   = e.rx;
        exp_q.push_back(e);
        n_expect++;
        start    = !init || collide;
        init_req = init;
        slow     = slw;
        tx_byte  = tx;
        @(posedge clk_sys);
        #1;
        start    = 1'b0;
        init_req = 1'b0;
        slow     = $urandom_range(0, 1);
        tx_byte  = 8'($urandom);
        if (collide) begin
            repeat (3) @(posedge clk_sys);
            #1;
            start   = 1'b1;
            tx_byte = 8'($urandom);
            @(posedge clk_sys);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        if (busy) drv_timeouts++;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_op(input bit init, input bit slw, input bit cs, input logic [7:0] tx,
                         input bit card, input logic [7:0] cb, input bit collide);
        issue(init, slw, cs, tx, card, cb, collide);
        wait_idle(13000);
    endtask

    initial begin
        bit         init, slw, card, cs, collide;
        int         r;
        reset_n = 1'b0; start = 1'b0; init_req = 1'b0; slow = 1'b0;
        cs_assert = 1'b0; tx_byte = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);

        do_op(0, 0, 0, 8'hA5, 0, 8'h00, 0);
        do_op(0, 0, 1, 8'hFF, 1, 8'h3C, 0);
        do_op(1, 1, 0, 8'h00, 0, 8'h00, 0);
        do_op(1, 0, 1, 8'h77, 0, 8'h00, 1);

        issue(0, 0, 0, 8'h33, 0, 8'h00, 0);
        repeat (17) @(posedge clk_sys);
        #3 reset_n = 1'b0;
        n_expect--;
        model_rx = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        do_op(0, 0, 0, 8'h5A, 0, 8'h00, 0);

        for (int i = 0; i < 24; i++) begin
            r       = $urandom_range(0, 9);
            init    = (r == 0);
            slw     = (r >= 8);
            cs      = $urandom_range(0, 1);
            card    = $urandom_range(0, 1);
            collide = init && ($urandom_range(0, 1) == 1);
            do_op(init, slw, cs, 8'($urandom), card, 8'($urandom), collide);
        end

        repeat (5) @(posedge clk_sys);
        finish_req = 1;
    end
endmodule
